// File: rtl/dsel_pkg.sv
// Shared types and helpers for the registered read-data arbiter (dsel_arb_rd).
package dsel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAITD = 2'd1,
        DONE  = 2'd2
    } dsel_state_t;

    // Open-bus value driven when nothing answers a read.
    localparam int unsigned DSEL_FILL_DEF = 0;

    function automatic int dsel_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dsel_prienc.sv
// Priority encoder over chip selects: lowest set bit wins, plus any/multi hit flags.
module dsel_prienc
    import dsel_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int SW   = (dsel_clog2(NSRC) < 1) ? 1 : dsel_clog2(NSRC)
) (
    input  logic [NSRC-1:0] en,
    output logic [SW-1:0]   sel,
    output logic            hit,
    output logic            multi
);

    always_comb begin
        sel = '0;
        // Walk downwards so the lowest index is written last and wins.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (en[i]) sel = SW'(i);
        end
    end

    assign hit   = |en;
    assign multi = |(en & (en - NSRC'(1)));

endmodule

// File: rtl/dsel_arb_rd.sv
// Registered read-data arbiter: merges NSRC select/data/ready sources onto the CPU bus.
// Build option DSEL_ARB_KEEPER_EN: a no-select read keeps the previous OUT (open-bus keeper).
module dsel_arb_rd
    import dsel_pkg::*;
#(
    parameter int              NSRC = 4,
    parameter int              DW   = 8,
    parameter int              TMO  = 15,
    parameter logic [DW-1:0]   FILL = DW'(DSEL_FILL_DEF)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               RD,
    input  logic [NSRC-1:0]    EN,
    input  logic [NSRC*DW-1:0] DT,
    input  logic [NSRC-1:0]    RDY,
    input  logic               CLR,
    output logic [DW-1:0]      OUT,
    output logic               VALID,
    output logic               WAIT,
    output logic               CONFLICT,
    output logic               TMOERR
);

    localparam int SW = (dsel_clog2(NSRC) < 1) ? 1 : dsel_clog2(NSRC);
    localparam int CW = (dsel_clog2(TMO + 1) < 1) ? 1 : dsel_clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);

    dsel_state_t   state_q, state_n;
    logic          rd_q, rd_edge;
    logic [SW-1:0] sel_c, sel_q, sel_n;
    logic          hit_c, multi_c;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [DW-1:0] out_q, out_n;
    logic          valid_q, valid_n;
    logic          wait_q, wait_n;
    logic          conflict_q, conflict_n;
    logic          tmoerr_q, tmoerr_n;
    logic [DW-1:0] dt_a [NSRC];

    for (genvar g = 0; g < NSRC; g++) begin : g_unpack
        assign dt_a[g] = DT[g*DW +: DW];
    end

    dsel_prienc #(.NSRC(NSRC), .SW(SW)) u_prienc (
        .en    (EN),
        .sel   (sel_c),
        .hit   (hit_c),
        .multi (multi_c)
    );

    assign rd_edge = RD & ~rd_q;

    always_comb begin
        state_n    = state_q;
        sel_n      = sel_q;
        cnt_n      = cnt_q;
        out_n      = out_q;
        valid_n    = 1'b0;
        wait_n     = wait_q;
        conflict_n = conflict_q & ~CLR;
        tmoerr_n   = tmoerr_q & ~CLR;
        case (state_q)
            IDLE: begin
                if (rd_edge) begin
                    sel_n = sel_c;
                    if (multi_c) conflict_n = 1'b1;
                    if (!hit_c) begin
`ifdef DSEL_ARB_KEEPER_EN
                        out_n = out_q;
`else
                        out_n = FILL;
`endif
                        valid_n = 1'b1;
                        state_n = DONE;
                    end else if (RDY[sel_c]) begin
                        out_n   = dt_a[sel_c];
                        valid_n = 1'b1;
                        state_n = DONE;
                    end else begin
                        wait_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = WAITD;
                    end
                end
            end
            WAITD: begin
                // Abort beats both completion and timeout.
                if (!RD) begin
                    wait_n  = 1'b0;
                    state_n = IDLE;
                end else if (RDY[sel_q]) begin
                    out_n   = dt_a[sel_q];
                    valid_n = 1'b1;
                    wait_n  = 1'b0;
                    state_n = DONE;
                end else if (TMO != 0 && cnt_q == TMO_LAST) begin
                    out_n    = FILL;
                    valid_n  = 1'b1;
                    wait_n   = 1'b0;
                    tmoerr_n = 1'b1;
                    state_n  = DONE;
                end else if (cnt_q != '1) begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (!RD) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            sel_q      <= '0;
            cnt_q      <= '0;
            out_q      <= FILL;
            valid_q    <= 1'b0;
            wait_q     <= 1'b0;
            conflict_q <= 1'b0;
            tmoerr_q   <= 1'b0;
        end else begin
            state_q    <= state_n;
            rd_q       <= RD;
            sel_q      <= sel_n;
            cnt_q      <= cnt_n;
            out_q      <= out_n;
            valid_q    <= valid_n;
            wait_q     <= wait_n;
            conflict_q <= conflict_n;
            tmoerr_q   <= tmoerr_n;
        end
    end

    assign OUT      = out_q;
    assign VALID    = valid_q;
    assign WAIT     = wait_q;
    assign CONFLICT = conflict_q;
    assign TMOERR   = tmoerr_q;

endmodule
